// File: rtl/reg_file_wb.sv
// -----------------------------------------------------------------------------
// reg_file_wb
//   8 x 8-bit register file for the ALU write-back path. One write port and
//   two independent combinational read ports. After reset a clear sequence
//   walks the array, zeroing one register per clock. While it runs, BUSY is
//   high, the read ports return zero and writes are refused.
//
// Parameters
//   BYPASS       1: a same-cycle write is forwarded to a matching read port
//                0: read ports show the stored value only
//
// Ports
//   CLK          single clock; all state changes on the rising edge
//   RESET        synchronous, active-low reset
//   IN[7:0]      write-back data
//   INADDRESS    destination register index
//   WRITE        write request, sampled on the rising edge
//   OUT1ADDRESS  read port 1 index
//   OUT2ADDRESS  read port 2 index
//   REGOUT1      read port 1 data
//   REGOUT2      read port 2 data
//   BUSY         clear sequence in progress
//   ZFLAG        last accepted write data was zero
//   DROP         one-cycle pulse: a write was refused during the clear
// -----------------------------------------------------------------------------
module reg_file_wb #(
  parameter int BYPASS = 0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] IN,
  input  logic [2:0] INADDRESS,
  input  logic       WRITE,
  input  logic [2:0] OUT1ADDRESS,
  input  logic [2:0] OUT2ADDRESS,
  output logic [7:0] REGOUT1,
  output logic [7:0] REGOUT2,
  output logic       BUSY,
  output logic       ZFLAG,
  output logic       DROP
);

  localparam int   DATA_W = 8;
  localparam bit   BYP    = (BYPASS != 0);

  localparam logic CLEAR  = 1'b0;
  localparam logic READY  = 1'b1;

  logic              state;
  logic [2:0]        cnt;
  logic              zflag_r;
  logic              drop_r;
  logic [DATA_W-1:0] regs [8];

  // Control: clear-sequence FSM, zero flag and refused-write pulse.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state   <= CLEAR;
      cnt     <= 3'd0;
      zflag_r <= 1'b0;
      drop_r  <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          // cnt wraps 7 -> 0 on its own as the sequence completes
          cnt    <= cnt + 3'd1;
          drop_r <= WRITE;
          if (cnt == 3'd7) state <= READY;
        end
        READY: begin
          drop_r <= 1'b0;
          if (WRITE) zflag_r <= (IN == '0);
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Storage: register 0 is zeroed directly by reset; the clear sequence
  // rewrites it (and all others) once reset is released.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      regs[0] <= '0;
    end else if (state == CLEAR) begin
      regs[cnt] <= '0;
    end else if (WRITE) begin
      regs[INADDRESS] <= IN;
    end
  end

  function automatic logic [DATA_W-1:0] rd_port(
    input logic              busy_i,
    input logic [2:0]        addr,
    input logic              wr,
    input logic [2:0]        wr_addr,
    input logic [DATA_W-1:0] wr_data,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] r;
    if (busy_i)
      r = '0;
    else if (BYP && wr && (wr_addr == addr))
      r = wr_data;
    else
      r = stored;
    return r;
  endfunction

  assign BUSY    = (state == CLEAR);
  assign ZFLAG   = zflag_r;
  assign DROP    = drop_r;
  assign REGOUT1 = rd_port(BUSY, OUT1ADDRESS, WRITE, INADDRESS, IN, regs[OUT1ADDRESS]);
  assign REGOUT2 = rd_port(BUSY, OUT2ADDRESS, WRITE, INADDRESS, IN, regs[OUT2ADDRESS]);

endmodule
